// File: rtl/tx_operand_streamer.sv
// Streams `length` consecutive TX RAM words from `base_addr` to the multiplier as a valid/ready stream.
// Latency: first out_valid 3 cycles after the accepted start, then one word per cycle with out_ready held high.
// Backpressure: 2-entry output FIFO; issue is throttled, and a blocked RAM word is re-read from the held address.
// Optional: define TX_STREAM_LAST_EN to add out_last on the final word of a run.
module tx_operand_streamer #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  ram_clock,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic [ADDR_WIDTH-1:0] addr_arith,
    input  logic [DATA_WIDTH-1:0] q_arith,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef TX_STREAM_LAST_EN
    output logic                  out_last,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words_sent
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO = 0;

    state_t                state;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   issued;
    logic                  addr_pend;  // address registered, RAM sampling it this cycle
    logic                  inflight;   // q_arith carries the word to capture this cycle
    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            fifo_count;

    logic       pop;
    logic       push;
    logic       can_issue;
    logic       start_go;
    logic [1:0] occ;

    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = fifo_mem[rd_ptr];
    assign pop       = out_valid && out_ready;
    assign occ       = fifo_count + {1'b0, inflight};
    assign can_issue = (occ < 2'd2) || ((occ == 2'd2) && pop);
    // A word that finds the FIFO full stays on q_arith: no issue can follow it, so the address holds.
    assign push      = inflight && ((fifo_count != 2'd2) || pop);
    assign start_go  = (state == IDLE) && start && (length != CNT_ZERO);

`ifdef TX_STREAM_LAST_EN
    assign out_last  = out_valid && (words_sent == (len_q - CNT_ONE));
`endif

    always_ff @(posedge ram_clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            len_q       <= '0;
            issued      <= '0;
            addr_pend   <= 1'b0;
            inflight    <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
            addr_arith  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            words_sent  <= '0;
        end else begin
            done      <= 1'b0;
            addr_pend <= start_go || ((state == RUN) && can_issue);
            inflight  <= addr_pend || (inflight && !push);

            if (push) begin
                fifo_mem[wr_ptr] <= q_arith;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase

            if (pop && (words_sent != len_q)) begin
                words_sent <= words_sent + CNT_ONE;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        len_q      <= length;
                        words_sent <= '0;
                        if (length == CNT_ZERO) begin
                            done <= 1'b1;
                        end else begin
                            busy       <= 1'b1;
                            addr_arith <= base_addr;
                            issued     <= CNT_ONE;
                            state      <= (length == CNT_ONE) ? DRAIN : RUN;
                        end
                    end
                end
                RUN: begin
                    if (can_issue) begin
                        addr_arith <= addr_arith + ADDR_ONE;
                        issued     <= issued + CNT_ONE;
                        if ((issued + CNT_ONE) == len_q) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if ((fifo_count == 2'd0) && !inflight && !addr_pend) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
